yblock_edge_port: RTL and testbench

//  Synchronous-to-Morphle edge adapter for one side of a yellow-cell block array.
//  TX half converts a host valid/ready word into one dual-rail token per lane, drives
//  it into the block's signal inputs and completes the four-phase return-to-empty

---
 rtl/yblock_edge_port.sv | 158 +++++++++++++++
 tb/tb_yblock_edge_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/yblock_edge_port.sv
// rtl/yblock_edge_port.sv - synchronous-to-Morphle dual-rail edge adapter (TX and RX halves)
module yblock_edge_port #(
    parameter int LANES       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [LANES-1:0]   tx_data,
    output logic [2*LANES-1:0] tx_sig,
    input  logic [2*LANES-1:0] tx_back,
    input  logic [2*LANES-1:0] rx_sig,
    output logic [2*LANES-1:0] rx_ack,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [LANES-1:0]   rx_data,
    output logic               err,
    input  logic               err_clr
);
    localparam int W = 2 * LANES;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {T_IDLE, T_DRIVE, T_RTZ, T_ERR} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_HOLD, R_RTZ, R_ERR} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [W-1:0] back_sync [SYNC_STAGES];
    logic [W-1:0] rx_sync   [SYNC_STAGES];
    logic [W-1:0] back_s, rx_s, rx_prev, rx_code, tx_enc;
    logic [LANES-1:0] rx_dec;
    logic [7:0] tx_cnt, rx_cnt;
    logic back_empty, back_ill, back_bad;
    logic rx_full, rx_empty, rx_ill, rx_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                back_sync[i] <= '0;
                rx_sync[i]   <= '0;
            end
        end else begin
            back_sync[0] <= tx_back;
            rx_sync[0]   <= rx_sig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                back_sync[i] <= back_sync[i-1];
                rx_sync[i]   <= rx_sync[i-1];
            end
        end
    end

    assign back_s = back_sync[SYNC_STAGES-1];
    assign rx_s   = rx_sync[SYNC_STAGES-1];

    // Per-lane classification; V1 is 2'b10 so its high bit is the decoded data bit
    always_comb begin
        back_empty = 1'b1;
        back_ill   = 1'b0;
        back_bad   = 1'b0;
        rx_full    = 1'b1;
        rx_empty   = 1'b1;
        rx_ill     = 1'b0;
        rx_bad     = 1'b0;
        tx_enc     = '0;
        rx_dec     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (back_s[2*i +: 2] != 2'b00) back_empty = 1'b0;
            if (back_s[2*i +: 2] == 2'b11) back_ill = 1'b1;
            if (back_s[2*i +: 2] != 2'b00 && back_s[2*i +: 2] != tx_sig[2*i +: 2]) back_bad = 1'b1;
            if (rx_s[2*i +: 2] == 2'b00) rx_full = 1'b0;
            else rx_empty = 1'b0;
            if (rx_s[2*i +: 2] == 2'b11) rx_ill = 1'b1;
            if (rx_s[2*i +: 2] != 2'b00 && rx_s[2*i +: 2] != rx_code[2*i +: 2]) rx_bad = 1'b1;
            tx_enc[2*i +: 2] = tx_data[i] ? 2'b10 : 2'b01;
            rx_dec[i] = rx_s[2*i+1];
        end
    end

    assign tx_ready = reset_n && (tx_state == T_IDLE) && back_empty;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (back_ill) tx_next = T_ERR;
                     else if (tx_valid && back_empty) tx_next = T_DRIVE;
            T_DRIVE: if (back_bad) tx_next = T_ERR;
                     else if (back_s == tx_sig) tx_next = T_RTZ;
                     else if (tx_cnt == TO_LAST) tx_next = T_ERR;
            T_RTZ:   if (back_ill) tx_next = T_ERR;
                     else if (back_empty) tx_next = T_IDLE;
                     else if (tx_cnt == TO_LAST) tx_next = T_ERR;
            default: tx_next = T_ERR;
        endcase
        if (err_clr) tx_next = T_IDLE;
    end

    // rx_bad also covers code 3, since a captured word never holds it
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_ill) rx_next = R_ERR;
                     else if (rx_full && rx_s == rx_prev) rx_next = R_HOLD;
            R_HOLD:  if (rx_ill) rx_next = R_ERR;
                     else if (rx_valid && rx_ready) rx_next = R_RTZ;
            R_RTZ:   if (rx_bad) rx_next = R_ERR;
                     else if (rx_empty) rx_next = R_IDLE;
                     else if (rx_cnt == TO_LAST) rx_next = R_ERR;
            default: rx_next = R_ERR;
        endcase
        if (err_clr) rx_next = R_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= T_IDLE;
            rx_state <= R_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sig   <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            rx_prev  <= '0;
            rx_code  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ack   <= '0;
            err      <= 1'b0;
        end else begin
            rx_prev  <= rx_s;
            tx_sig   <= (tx_next == T_DRIVE) ? ((tx_state == T_IDLE) ? tx_enc : tx_sig) : '0;
            rx_valid <= (rx_next == R_HOLD);
            rx_ack   <= (rx_next == R_RTZ) ? rx_code : '0;
            if (err_clr || tx_next != tx_state) tx_cnt <= '0;
            else if (tx_state == T_DRIVE || tx_state == T_RTZ) tx_cnt <= tx_cnt + 8'd1;
            if (err_clr || rx_next != rx_state) rx_cnt <= '0;
            else if (rx_state == R_RTZ) rx_cnt <= rx_cnt + 8'd1;
            if (err_clr) begin
                rx_data <= '0;
                rx_code <= '0;
            end else if (rx_state == R_IDLE && rx_next == R_HOLD) begin
                rx_data <= rx_dec;
                rx_code <= rx_s;
            end
            if (err_clr) err <= 1'b0;
            else if ((tx_next == T_ERR && tx_state != T_ERR) ||
                     (rx_next == R_ERR && rx_state != R_ERR)) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_yblock_edge_port.sv
// tb/tb_yblock_edge_port.sv - self-checking bench for yblock_edge_port
module tb_yblock_edge_port;
    localparam int LANES = 8;
    localparam int SS    = 2;
    localparam int TO    = 255;

    logic        clk;
    logic        reset_n;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic [15:0] tx_sig, tx_back, rx_sig, rx_ack;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        err, err_clr;

    int pass_cnt = 0;
    int total_cnt = 0;

    yblock_edge_port #(.LANES(LANES), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_sig(tx_sig), .tx_back(tx_back),
        .rx_sig(rx_sig), .rx_ack(rx_ack),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .err(err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  data;
        logic [15:0] sig;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: lane i carries 2 (V1) or 1 (V0) at weight 4**i
    function automatic logic [15:0] model_enc(input logic [7:0] d);
        int r = 0;
        for (int i = 0; i < LANES; i++) r += (d[i] ? 2 : 1) * (1 << (2 * i));
        return r[15:0];
    endfunction

    task automatic do_tx(input logic [7:0] d, input logic [15:0] exp, input int delay);
        int k;
        tx_data = d;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 50) begin @(negedge clk); k++; end
        check("tx_ready_before", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_sig_word", tx_sig, exp);
        check("tx_ready_busy", tx_ready, 0);
        repeat (delay) @(negedge clk);
        tx_back = exp;
        k = 0;
        while (tx_sig != 16'h0 && k < 20) begin @(negedge clk); k++; end
        check("tx_sig_rtz", tx_sig, 0);
        check("tx_ready_rtz", tx_ready, 0);
        tx_back = 16'h0;
        k = 0;
        while (!tx_ready && k < 20) begin @(negedge clk); k++; end
        check("tx_ready_after", tx_ready, 1);
        check("tx_err", err, 0);
    endtask

    task automatic do_rx(input logic [15:0] sig, input logic [7:0] exp, input int stall);
        int k;
        rx_sig = sig;
        rx_ready = 1'b0;
        repeat (SS + 1) @(negedge clk);
        check("rx_valid_early", rx_valid, 0);
        @(negedge clk);
        check("rx_valid", rx_valid, 1);
        check("rx_data", rx_data, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("rx_hold_valid", rx_valid, 1);
            check("rx_hold_ack", rx_ack, 0);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_valid_drop", rx_valid, 0);
        check("rx_ack", rx_ack, sig);
        rx_sig = 16'h0;
        k = 0;
        while (rx_ack != 16'h0 && k < 20) begin @(negedge clk); k++; end
        check("rx_ack_rtz", rx_ack, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] d;
        int k;
        logic saw;
        vecs[0] = '{8'hA5, 16'h9966};
        vecs[1] = '{8'h00, 16'h5555};
        vecs[2] = '{8'hFF, 16'hAAAA};
        vecs[3] = '{8'h5A, 16'h6699};
        vecs[4] = '{8'h01, 16'h5556};
        vecs[5] = '{8'h80, 16'h9555};

        reset_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h0; tx_back = 16'h0;
        rx_sig = 16'h0; rx_ready = 1'b0; err_clr = 1'b0;
        #12;
        check("rst_tx_sig", tx_sig, 0);
        check("rst_rx_ack", rx_ack, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_err", err, 0);
        check("rst_tx_ready", tx_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_tx_ready", tx_ready, 1);

        // Directed word tables, TX then RX
        for (int i = 0; i < 6; i++) do_tx(vecs[i].data, vecs[i].sig, 3);
        for (int i = 0; i < 6; i++) do_rx(vecs[i].sig, vecs[i].data, (i == 3) ? 10 : 1);

        // Random words, both halves concurrently
        for (int n = 0; n < 20; n++) begin
            logic [7:0] td, rd;
            int dl, st;
            td = 8'($urandom);
            rd = 8'($urandom);
            dl = $urandom_range(0, 5);
            st = $urandom_range(0, 3);
            fork
                do_tx(td, model_enc(td), dl);
                do_rx(model_enc(rd), rd, st);
            join
        end

        // Lane 0 returns V0 while V1 is driven
        tx_data = 8'h01; tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        tx_valid = 1'b0;
        check("mm_tx_sig", tx_sig, 16'h5556);
        tx_back = 16'h5555;
        k = 0;
        while (!err && k < 10) begin @(negedge clk); k++; end
        check("mm_err", err, 1);
        check("mm_tx_sig_off", tx_sig, 0);
        check("mm_tx_ready", tx_ready, 0);
        tx_back = 16'h0;
        repeat (3) @(negedge clk);
        check("mm_stuck", tx_ready, 0);
        pulse_clr();
        check("mm_err_clr", err, 0);
        check("mm_ready_back", tx_ready, 1);

        // Back never answers: timeout measured from entry to T_DRIVE
        tx_data = 8'hFF; tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        tx_valid = 1'b0;
        k = 0;
        while (!err && k < TO + 5) begin @(negedge clk); k++; end
        check("timeout_cycles", k, TO);
        check("timeout_tx_sig", tx_sig, 0);
        pulse_clr();
        check("timeout_clr", err, 0);
        check("timeout_ready", tx_ready, 1);

        // Code 3 on rx lane 7, then clear while the error source persists
        rx_sig = 16'hD555; rx_ready = 1'b1; saw = 1'b0;
        k = 0;
        while (!err && k < 10) begin @(negedge clk); k++; if (rx_valid) saw = 1'b1; end
        check("ill_err", err, 1);
        check("ill_no_valid", saw, 0);
        pulse_clr();
        check("ill_clr_priority", err, 0);
        rx_sig = 16'h0; rx_ready = 1'b0;
        repeat (5) @(negedge clk);
        pulse_clr();
        check("ill_clr_final", err, 0);
        check("ill_rx_valid", rx_valid, 0);

        // Async reset with TX in T_RTZ and RX in R_HOLD
        rx_sig = 16'h6699;
        k = 0;
        while (!rx_valid && k < 10) begin @(negedge clk); k++; end
        check("ar_rx_valid", rx_valid, 1);
        tx_data = 8'hA5; tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_back = 16'h9966;
        k = 0;
        while (tx_sig != 16'h0 && k < 20) begin @(negedge clk); k++; end
        check("ar_in_rtz", tx_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("ar_tx_sig", tx_sig, 0);
        check("ar_rx_ack", rx_ack, 0);
        check("ar_rx_valid0", rx_valid, 0);
        check("ar_rx_data", rx_data, 0);
        check("ar_err", err, 0);
        check("ar_tx_ready", tx_ready, 0);
        rx_sig = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_back_busy", tx_ready, 0);
        tx_back = 16'h0;
        repeat (3) @(negedge clk);
        check("ar_back_empty", tx_ready, 1);
        check("ar_rx_idle", rx_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
